uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmit engine between `N_REQ` byte producers (firmware CSR path, debug/trace path, loopback echo, ...). It accepts one byte at a time from a selected requester and sequences the transmitter's start / clear-request / busy handshake. It supports multi-byte locked frames and a start-acknowledge timeout. It sits between the requesters and the transmitter inside the UART user block, in the Wishbone clock domain.

---
 rtl/uart_tx_arbiter_if.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side handshake bundle for the UART TX arbiter.
// master = arbiter view, slave = requesters plus transmitter view.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ = 2
) ();
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_lock;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               tx_clear_req;
    logic               tx_busy;

    modport master (
        input  req_valid, req_data, req_lock, tx_clear_req, tx_busy,
        output req_ready, tx_data, tx_start
    );

    modport slave (
        output req_valid, req_data, req_lock, tx_clear_req, tx_busy,
        input  req_ready, tx_data, tx_start
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit engine between N_REQ byte producers,
// with locked multi-byte ownership and a start-acknowledge timeout.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ         = 2,
    parameter int unsigned START_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    uart_tx_arbiter_if.master      bus,
    output logic [2:0]             owner,
    output logic                   locked,
    output logic [15:0]            sent_cnt,
    output logic                   timeout_err
);

    localparam int unsigned CNT_W = $clog2(START_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] req_ready_q, req_ready_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_start_q, tx_start_d;
    logic [2:0]       owner_q, owner_d;
    logic             locked_q, locked_d;
    logic [15:0]      sent_cnt_q, sent_cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

    logic [N_REQ-1:0] elig;
    logic             gnt_found;
    logic [2:0]       gnt_idx;
    logic [7:0]       gnt_data;
    logic             gnt_lock;

    // Round-robin pick starting after the last owner; a held lock narrows eligibility to the owner.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        elig      = locked_q ? (bus.req_valid & (N_REQ'(1) << owner_q)) : bus.req_valid;
        gnt_found = 1'b0;
        gnt_idx   = owner_q;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = 32'(owner_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!gnt_found && (|(elig & (N_REQ'(1) << idx)))) begin
                gnt_found = 1'b1;
                gnt_idx   = 3'(idx);
            end
        end
        gnt_data = 8'(bus.req_data >> (8 * gnt_idx));
        gnt_lock = |(bus.req_lock & (N_REQ'(1) << gnt_idx));
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        req_ready_d   = '0;
        tx_data_d     = tx_data_q;
        tx_start_d    = 1'b0;
        owner_d       = owner_q;
        locked_d      = locked_q;
        sent_cnt_d    = sent_cnt_q;
        timeout_err_d = 1'b0;
        to_cnt_d      = to_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (enable && !bus.tx_busy && gnt_found) begin
                    state_d     = S_START;
                    req_ready_d = N_REQ'(1) << gnt_idx;
                    tx_data_d   = gnt_data;
                    owner_d     = gnt_idx;
                    locked_d    = gnt_lock;
                    to_cnt_d    = '0;
                end
            end
            S_START: begin
                // Clear beats the terminal count; counting only runs while tx_start is visible.
                if (bus.tx_clear_req) begin
                    state_d = S_WAIT_HI;
                end else if (tx_start_q && (to_cnt_q == CNT_LAST)) begin
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                    locked_d      = 1'b0;
                end else begin
                    tx_start_d = 1'b1;
                    if (tx_start_q) begin
                        to_cnt_d = to_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!bus.tx_busy) begin
                    state_d    = S_IDLE;
                    sent_cnt_d = sent_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            req_ready_q   <= '0;
            tx_data_q     <= 8'h00;
            tx_start_q    <= 1'b0;
            owner_q       <= 3'(N_REQ - 1);
            locked_q      <= 1'b0;
            sent_cnt_q    <= 16'h0000;
            timeout_err_q <= 1'b0;
            to_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            owner_q       <= owner_d;
            locked_q      <= locked_d;
            sent_cnt_q    <= sent_cnt_d;
            timeout_err_q <= timeout_err_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_start  = tx_start_q;
    assign owner         = owner_q;
    assign locked        = locked_q;
    assign sent_cnt      = sent_cnt_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requester models, a transmitter model feeding a
// scoreboard of expected bytes, and directed sequences for timeout, enable and reset.
module tb_uart_tx_arbiter;
    localparam int unsigned N_REQ         = 2;
    localparam int unsigned START_TIMEOUT = 1024;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        enable = 1'b0;
    logic [2:0]  owner;
    logic        locked;
    logic [15:0] sent_cnt;
    logic        timeout_err;

    uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

    uart_tx_arbiter #(.N_REQ(N_REQ), .START_TIMEOUT(START_TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .bus         (bus),
        .owner       (owner),
        .locked      (locked),
        .sent_cnt    (sent_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] data; logic lock; } rq_t;
    typedef struct { logic [7:0] data; logic [2:0] owner; logic locked; } exp_t;
    typedef struct {
        int         req;
        logic [7:0] data;
        logic       lock;
        logic [7:0] exp_data;
        logic [2:0] exp_owner;
        logic       exp_locked;
    } vec_t;

    rq_t  rq [N_REQ][$];
    exp_t exp_q[$];
    vec_t tv [11];

    int n_chk      = 0;
    int n_pass     = 0;
    int n_grants   = 0;
    int to_pulses  = 0;
    bit no_clear   = 1'b0;
    int busy_delay = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_cnt(input logic [15:0] target, input string name);
        int n = 0;
        while (sent_cnt !== target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(sent_cnt), 32'(target));
    endtask

    task automatic push_req(input int r, input logic [7:0] d, input logic l);
        rq_t e;
        e.data = d;
        e.lock = l;
        rq[r].push_back(e);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [2:0] o, input logic l);
        exp_t e;
        e.data   = d;
        e.owner  = o;
        e.locked = l;
        exp_q.push_back(e);
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            push_req(tv[i].req, tv[i].data, tv[i].lock);
            push_exp(tv[i].exp_data, tv[i].exp_owner, tv[i].exp_locked);
        end
    endtask

    // Requester models: present the head of each queue, pop on accept.
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_lock  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.req_ready[i] && rq[i].size() > 0) rq[i].delete(0);
                if (rq[i].size() > 0) begin
                    bus.req_valid[i]       = 1'b1;
                    bus.req_data[8*i +: 8] = rq[i][0].data;
                    bus.req_lock[i]        = rq[i][0].lock;
                end else begin
                    bus.req_valid[i]       = 1'b0;
                    bus.req_data[8*i +: 8] = 8'h00;
                    bus.req_lock[i]        = 1'b0;
                end
            end
        end
    end

    // Transmitter model and scoreboard consumer.
    initial begin
        exp_t e;
        bus.tx_clear_req = 1'b0;
        bus.tx_busy      = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.tx_start && !no_clear) begin
                check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_tx_data", 32'(bus.tx_data), 32'(e.data));
                    check("sb_owner", 32'(owner), 32'(e.owner));
                    check("sb_locked", 32'(locked), 32'(e.locked));
                end
                bus.tx_clear_req = 1'b1;
                if (busy_delay == 0) bus.tx_busy = 1'b1;
                @(negedge clk);
                bus.tx_clear_req = 1'b0;
                for (int d = 1; d < busy_delay; d++) @(negedge clk);
                bus.tx_busy = 1'b1;
                repeat (4) @(negedge clk);
                bus.tx_busy = 1'b0;
            end
        end
    end

    // Grant and timeout-pulse monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (|bus.req_ready) begin
                    n_grants++;
                    check("ready_onehot", 32'($countones(bus.req_ready)), 32'd1);
                end
                if (timeout_err) to_pulses++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        int n;
        tv = '{
            '{0, 8'h11, 1'b0, 8'h11, 3'd0, 1'b0},
            '{0, 8'h12, 1'b0, 8'h21, 3'd1, 1'b0},
            '{0, 8'h13, 1'b0, 8'h12, 3'd0, 1'b0},
            '{1, 8'h21, 1'b0, 8'h22, 3'd1, 1'b0},
            '{1, 8'h22, 1'b0, 8'h13, 3'd0, 1'b0},
            '{1, 8'h23, 1'b0, 8'h23, 3'd1, 1'b0},
            '{0, 8'h30, 1'b0, 8'h30, 3'd0, 1'b0},
            '{0, 8'h31, 1'b0, 8'h41, 3'd1, 1'b1},
            '{1, 8'h41, 1'b1, 8'h42, 3'd1, 1'b1},
            '{1, 8'h42, 1'b1, 8'h43, 3'd1, 1'b0},
            '{1, 8'h43, 1'b0, 8'h31, 3'd0, 1'b0}
        };

        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_owner", 32'(owner), 32'(N_REQ - 1));
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_sent_cnt", 32'(sent_cnt), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Round-robin interleave, then a locked burst from requester 1.
        apply_vecs(0, 5);
        wait_cnt(16'd6, "cnt_rr");
        apply_vecs(6, 10);
        wait_cnt(16'd11, "cnt_lock");
        check("lock_released", 32'(locked), 32'd0);
        check("lock_owner", 32'(owner), 32'd0);
        g0 = n_grants;

        // Enable gating.
        enable = 1'b0;
        push_req(1, 8'h55, 1'b0);
        repeat (10) @(negedge clk);
        check("en0_no_grant", 32'(n_grants), 32'(g0));
        check("en0_tx_start", 32'(bus.tx_start), 32'd0);
        push_exp(8'h55, 3'd1, 1'b0);
        enable = 1'b1;
        @(negedge clk);
        check("en1_grant", 32'(bus.req_ready), 32'h2);
        enable = 1'b0;
        push_req(0, 8'h66, 1'b0);
        wait_cnt(16'd12, "cnt_en_drop");
        repeat (10) @(negedge clk);
        check("en_drop_no_grant", 32'(n_grants), 32'(g0 + 1));
        push_exp(8'h66, 3'd0, 1'b0);
        enable = 1'b1;
        wait_cnt(16'd13, "cnt_en_resume");

        // Busy rising with the clear, then three cycles after it.
        busy_delay = 0;
        push_exp(8'h71, 3'd1, 1'b0);
        push_req(1, 8'h71, 1'b0);
        wait_cnt(16'd14, "cnt_busy0");
        repeat (10) @(negedge clk);
        check("busy0_single", 32'(sent_cnt), 32'd14);
        busy_delay = 3;
        push_exp(8'h72, 3'd0, 1'b0);
        push_req(0, 8'h72, 1'b0);
        wait_cnt(16'd15, "cnt_busy3");
        repeat (10) @(negedge clk);
        check("busy3_single", 32'(sent_cnt), 32'd15);
        check("busy_grants", 32'(n_grants), 32'(g0 + 4));
        busy_delay = 1;

        // Start timeout on a locked byte; the other requester must be served afterwards.
        no_clear = 1'b1;
        push_req(1, 8'h81, 1'b1);
        push_req(0, 8'h82, 1'b0);
        n = 0;
        while (!bus.tx_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("to_tx_start_seen", 32'(bus.tx_start), 32'd1);
        n = 0;
        while (bus.tx_start && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check("to_start_cycles", 32'(n), 32'(START_TIMEOUT));
        check("to_locked_clr", 32'(locked), 32'd0);
        check("to_sent_cnt", 32'(sent_cnt), 32'd15);
        @(negedge clk);
        check("to_pulse_count", 32'(to_pulses), 32'd1);
        push_exp(8'h82, 3'd0, 1'b0);
        no_clear = 1'b0;
        wait_cnt(16'd16, "cnt_after_to");

        // Asynchronous reset in the middle of a frame.
        push_exp(8'h91, 3'd1, 1'b0);
        push_req(1, 8'h91, 1'b0);
        n = 0;
        while (!bus.tx_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_busy_seen", 32'(bus.tx_busy), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tx_start", 32'(bus.tx_start), 32'd0);
        check("arst_tx_data", 32'(bus.tx_data), 32'd0);
        check("arst_owner", 32'(owner), 32'(N_REQ - 1));
        check("arst_sent_cnt", 32'(sent_cnt), 32'd0);
        check("arst_req_ready", 32'(bus.req_ready), 32'd0);
        n = 0;
        while (bus.tx_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(8'hA1, 3'd0, 1'b0);
        push_exp(8'hA2, 3'd1, 1'b0);
        push_req(0, 8'hA1, 1'b0);
        push_req(1, 8'hA2, 1'b0);
        wait_cnt(16'd2, "cnt_after_rst");

        // Counter wrap from a forced preload.
        @(negedge clk);
        force dut.sent_cnt_q = 16'hFFFF;
        repeat (2) @(negedge clk);
        release dut.sent_cnt_q;
        @(negedge clk);
        check("wrap_preload", 32'(sent_cnt), 32'hFFFF);
        push_exp(8'hB1, 3'd0, 1'b0);
        push_req(0, 8'hB1, 1'b0);
        wait_cnt(16'd0, "cnt_wrap");

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("total_grants", 32'(n_grants), 32'd21);
        check("total_to_pulses", 32'(to_pulses), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
